traffic_light_ctrl: RTL
=======================

Name: traffic_light_ctrl

Overview:
Two-direction intersection controller, the parametrised successor of the fixed 8-bit red/yellow/green sequencer. Phase durations are runtime inputs of parametrised width. It adds all-red clearance, a latched pedestrian walk phase and a night flashing-yellow mode. It sits between the timing-config registers and the lamp driver outputs.

Parameters:
TW, 8, width of every duration input and of the phase timer
FLASH_HALF, 4, cycles per half-period of flashing yellow (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
t_green  in  TW  green duration in cycles, sampled on phase entry
t_yellow  in  TW  yellow duration in cycles, sampled on phase entry
t_allred  in  TW  all-red clearance in cycles, sampled on phase entry
t_walk  in  TW  extra all-red cycles granted when a pedestrian request is served
ped_req  in  1  pedestrian request, level or pulse, sampled every edge
flash_mode  in  1  night mode request
R1,Y1,G1  out  1  direction-1 lamps
R2,Y2,G2  out  1  direction-2 lamps
walk  out  1  pedestrian walk lamp
phase  out  3  current state encoding (debug/status)

Behaviour:
- States: ALLRED_A(0), G1(1), Y1(2), ALLRED_B(3), G2(4), Y2(5), FLASH(6).
- Normal cycle: ALLRED_A -> G1 -> Y1 -> ALLRED_B -> G2 -> Y2 -> ALLRED_A.
- Lamps are decoded from the registered state only; there is no input-to-output combinational path.
  - ALLRED_x: R1=R2=1.
  - G1: G1=R2=1.
  - Y1: Y1=R2=1.
  - G2: R1=G2=1.
  - Y2: R1=Y2=1.
  - FLASH: Y1=Y2=blink, all others 0.
- Phase timer: TW+1-bit down counter, loaded on phase entry with max(dur,1)-1.
  - The state advances on the edge where timer==0, so every phase lasts max(dur,1) cycles.
  - A zero duration gives a 1-cycle phase.
- Durations are sampled only on the entry edge. Changing them mid-phase has no effect until the next entry.
- Reset (async, rst_n=0):
  - state=ALLRED_A, timer=0, ped_pend=0, blink=1, flash counter=0.
  - Outputs: R1=R2=1, all others 0, walk=0, phase=0.
  - G1 is entered on the first rising edge after release.
  - Reset mid-phase aborts immediately to this state.
- Pedestrian:
  - ped_pend is set on any edge with ped_req=1.
  - On entry to ALLRED_A or ALLRED_B with ped_pend=1: duration = t_allred + t_walk (TW+1-bit sum, no overflow), walk=1 for that whole state, and ped_pend is cleared on the same edge.
  - If ped_req=1 on that entry edge, the set wins, so the request is re-latched for the next all-red.
  - A ped_req during a walk state is served at the next all-red.
- Flash mode:
  - flash_mode is evaluated only at phase boundaries (timer==0, non-FLASH state). If it is 1, the next state is FLASH instead of the normal successor.
  - On FLASH entry: blink=1, flash counter=0, ped_pend cleared. ped_req is ignored in FLASH.
  - blink toggles every FLASH_HALF cycles.
  - When flash_mode=0 in FLASH: next edge enters ALLRED_A with duration t_allred. The pedestrian extension never applies on this exit.
- Simultaneous events: flash entry has priority over pedestrian service at the same boundary.

Decomposition:
- Package tl_pkg: state enum tl_state_e with the encodings above, plus the 6-bit lamp pattern constants per state.
- Sub-module tl_phase_timer: TW+1-bit loadable down counter with load, load_val, zero outputs.
- The FSM and lamp decode stay in traffic_light_ctrl.

Test Plan:
- TW=8; t_green=5, t_yellow=2, t_allred=1, t_walk=0; release reset -> G1 for 5, Y1 for 2, ALLRED_B for 1, G2 for 5, Y2 for 2, ALLRED_A for 1; period 16; R1=R2=1 during reset.
- Same timing, t_walk=3; pulse ped_req for 1 cycle during G1 -> ALLRED_B lasts 4 cycles with walk=1; the following ALLRED_A lasts 1 cycle with walk=0.
- t_green=0 -> G1 and G2 each last exactly 1 cycle; t_green=255 with t_walk=255, t_allred=255 -> walk all-red lasts 510 cycles, no wrap.
- Assert flash_mode during G2 -> G2 completes, then FLASH; Y1=Y2 toggle every 4 cycles starting high; ped_req ignored. Deassert flash_mode -> ALLRED_A for t_allred cycles, then G1.
- Change t_green from 5 to 9 mid-G1 -> current G1 stays 5 cycles, the next G1 lasts 9.
- Drop rst_n asynchronously mid-Y2 with ped_pend set -> outputs go to R1=R2=1 without a clock edge; after release, no walk phase occurs.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types for the intersection controller: state encoding and lamp patterns.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tl_pkg;

   // Controller states; the encoding is visible on the phase output.
   typedef enum logic [2:0] {
      ST_ALLRED_A = 3'd0,
      ST_G1       = 3'd1,
      ST_Y1       = 3'd2,
      ST_ALLRED_B = 3'd3,
      ST_G2       = 3'd4,
      ST_Y2       = 3'd5,
      ST_FLASH    = 3'd6
   } tl_state_e;

   // Lamp vectors are ordered {R1, Y1, G1, R2, Y2, G2}.
   localparam logic [5:0] LAMP_ALLRED = 6'b100_100;
   localparam logic [5:0] LAMP_G1     = 6'b001_100;
   localparam logic [5:0] LAMP_Y1     = 6'b010_100;
   localparam logic [5:0] LAMP_G2     = 6'b100_001;
   localparam logic [5:0] LAMP_Y2     = 6'b100_010;

   // Lamp pattern for a state; in FLASH both yellows follow the blink phase.
   function automatic logic [5:0] lamp_pattern(input tl_state_e s, input logic blink);
      logic [5:0] p;
      case (s)
         ST_G1:    p = LAMP_G1;
         ST_Y1:    p = LAMP_Y1;
         ST_G2:    p = LAMP_G2;
         ST_Y2:    p = LAMP_Y2;
         ST_FLASH: p = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0};
         default:  p = LAMP_ALLRED;
      endcase
      return p;
   endfunction

   // Successor in the normal rotation. FLASH is never a normal successor.
   function automatic tl_state_e next_normal(input tl_state_e s);
      tl_state_e n;
      case (s)
         ST_ALLRED_A: n = ST_G1;
         ST_G1:       n = ST_Y1;
         ST_Y1:       n = ST_ALLRED_B;
         ST_ALLRED_B: n = ST_G2;
         ST_G2:       n = ST_Y2;
         ST_Y2:       n = ST_ALLRED_A;
         default:     n = ST_ALLRED_A;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_timer.sv
// Loadable down counter timing the current phase; zero marks the last cycle.
// Latency: load takes effect on the next edge; zero is decoded from the register.
// Backpressure: none; counts every cycle and holds at zero.
module tl_phase_timer #(
   parameter int TW = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [TW:0] load_val,
   output logic [TW:0] count,
   output logic        zero
);

   // Load wins over counting; the counter parks at zero until reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - (TW+1)'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-direction intersection sequencer with all-red clearance, pedestrian walk and night flash.
// Latency: lamps and phase are registered and change on the edge that enters a state.
// Backpressure: none; ped_req is latched every edge, flash_mode only acts at phase boundaries.
module traffic_light_ctrl
   import tl_pkg::*;
#(
   parameter int TW         = 8,
   parameter int FLASH_HALF = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [TW-1:0] t_green,
   input  logic [TW-1:0] t_yellow,
   input  logic [TW-1:0] t_allred,
   input  logic [TW-1:0] t_walk,
   input  logic          ped_req,
   input  logic          flash_mode,
   output logic          R1,
   output logic          Y1,
   output logic          G1,
   output logic          R2,
   output logic          Y2,
   output logic          G2,
   output logic          walk,
   output logic [2:0]    phase
);

   localparam int FCW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam logic [FCW-1:0] FCNT_LAST = FCW'(FLASH_HALF - 1);

   tl_state_e       state, nxt_state;
   logic            ped_pend, nxt_pend;
   logic            blink, nxt_blink;
   logic            nxt_walk;
   logic [FCW-1:0]  fcnt, nxt_fcnt;
   logic [5:0]      lamps;
   logic            tmr_load;
   logic [TW:0]     tmr_val;
   logic [TW:0]     tmr_count;
   logic            tmr_zero;
   logic [TW:0]     walk_sum;

   // A phase of duration d lasts max(d,1) cycles, so the timer is loaded with max(d,1)-1.
   function automatic logic [TW:0] phase_load(input logic [TW:0] d);
      return (d == '0) ? '0 : d - (TW+1)'(1);
   endfunction

   // One bit wider than the inputs so a pedestrian extension never wraps.
   assign walk_sum = {1'b0, t_allred} + {1'b0, t_walk};

   tl_phase_timer #(
      .TW (TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   // Next-state decision: flash entry beats pedestrian service at a boundary.
   always_comb begin
      nxt_state = state;
      nxt_walk  = walk;
      nxt_blink = blink;
      nxt_fcnt  = fcnt;
      nxt_pend  = ped_pend | ped_req;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      if (state == ST_FLASH) begin
         nxt_pend = 1'b0;
         if (!flash_mode) begin
            // Leaving flash always uses the plain clearance, never the walk extension.
            nxt_state = ST_ALLRED_A;
            nxt_walk  = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = phase_load({1'b0, t_allred});
         end else if (fcnt == FCNT_LAST) begin
            nxt_fcnt  = '0;
            nxt_blink = ~blink;
         end else begin
            nxt_fcnt = fcnt + FCW'(1);
         end
      end else if (tmr_zero) begin
         if (flash_mode) begin
            nxt_state = ST_FLASH;
            nxt_walk  = 1'b0;
            nxt_blink = 1'b1;
            nxt_fcnt  = '0;
            nxt_pend  = 1'b0;
         end else begin
            nxt_state = next_normal(state);
            nxt_walk  = 1'b0;
            tmr_load  = 1'b1;
            case (next_normal(state))
               ST_G1, ST_G2: tmr_val = phase_load({1'b0, t_green});
               ST_Y1, ST_Y2: tmr_val = phase_load({1'b0, t_yellow});
               default: begin
                  if (ped_pend) begin
                     // Serve the latched request; a request on this same edge re-latches.
                     tmr_val  = phase_load(walk_sum);
                     nxt_walk = 1'b1;
                     nxt_pend = ped_req;
                  end else begin
                     tmr_val = phase_load({1'b0, t_allred});
                  end
               end
            endcase
         end
      end
   end

   // State, pedestrian latch, blink and registered lamp outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ALLRED_A;
         ped_pend <= 1'b0;
         blink    <= 1'b1;
         fcnt     <= '0;
         walk     <= 1'b0;
         lamps    <= LAMP_ALLRED;
      end else begin
         state    <= nxt_state;
         ped_pend <= nxt_pend;
         blink    <= nxt_blink;
         fcnt     <= nxt_fcnt;
         walk     <= nxt_walk;
         lamps    <= lamp_pattern(nxt_state, nxt_blink);
      end
   end

   assign {R1, Y1, G1, R2, Y2, G2} = lamps;
   assign phase = state;

endmodule
